// File: rtl/uart_bridge_pkg.sv
// uart_tx_bridge shared types: drain FSM states, status bit indices, bytes.
// Optional CR/LF expansion is enabled by defining UART_TX_CRLF_EN.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    CR_SEND = 2'd2
  } state_e;

  localparam int ST_TX_NOT_FULL = 0;
  localparam int ST_RX_AVAIL    = 1;
  localparam int ST_TX_EMPTY    = 2;
  localparam int ST_OVF         = 3;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head and occupancy count.
// Caller guarantees no push when full (unless popping) and no pop when empty.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_bridge.sv
// CPU bus to simpleuart bridge: TX FIFO drain, RX capture, status byte.
// Define UART_TX_CRLF_EN to expand LF into CR,LF on the UART side.
module uart_tx_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_wr,
  input  logic       bus_rd,
  input  logic       bus_stat_rd,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic [7:0] bus_status,
  output logic       uart_we,
  output logic [7:0] uart_di,
  input  logic       uart_wait,
  output logic       uart_re,
  input  logic [7:0] uart_do,
  input  logic       uart_valid
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic wr_hist_q, rd_hist_q, stat_hist_q;
  logic ev_wr, ev_rd, ev_stat;

  state_e     state_q, state_d;
  logic       we_q, we_d;
  logic [7:0] di_q, di_d;
  logic       re_q;
  logic [7:0] rdata_q, rdata_d;
  logic       ovf_q, ovf_d;

  logic [7:0]          head;
  logic [DEPTH_LOG2:0] count;
  logic                push, pop;
  logic                full, empty;
  logic                ovf_set;

`ifdef UART_TX_CRLF_EN
  logic lf_done_q, lf_done_d;
  logic need_cr;
  assign need_cr = (head == CHAR_LF) && !lf_done_q;
`endif

  assign ev_wr   = bus_wr && !wr_hist_q;
  assign ev_rd   = bus_rd && !rd_hist_q;
  assign ev_stat = bus_stat_rd && !stat_hist_q;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push    = ev_wr && (!full || pop);
  assign ovf_set = ev_wr && full && !pop;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus_wdata),
    .head_o  (head),
    .count_o (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      di_q    <= '0;
`ifdef UART_TX_CRLF_EN
      lf_done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      di_q    <= di_d;
`ifdef UART_TX_CRLF_EN
      lf_done_q <= lf_done_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
`ifdef UART_TX_CRLF_EN
          if (need_cr) state_d = CR_SEND;
          else         state_d = SEND;
`else
          state_d = SEND;
`endif
        end
      end
      SEND, CR_SEND: if (!uart_wait) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d = we_q;
    di_d = di_q;
    pop  = 1'b0;
`ifdef UART_TX_CRLF_EN
    lf_done_d = lf_done_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          we_d = 1'b1;
          di_d = head;
`ifdef UART_TX_CRLF_EN
          if (need_cr) di_d = CHAR_CR;
`endif
        end
      end
      SEND: begin
        if (!uart_wait) begin
          we_d = 1'b0;
          pop  = 1'b1;
`ifdef UART_TX_CRLF_EN
          lf_done_d = 1'b0;
`endif
        end
      end
      CR_SEND: begin
        if (!uart_wait) begin
          we_d = 1'b0;
`ifdef UART_TX_CRLF_EN
          lf_done_d = 1'b1;
`endif
        end
      end
      default: we_d = 1'b0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (ev_rd) rdata_d = uart_do;
    // Set beats clear so a drop during the status read is not lost.
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ev_stat) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_hist_q   <= 1'b0;
      rd_hist_q   <= 1'b0;
      stat_hist_q <= 1'b0;
      re_q        <= 1'b0;
      rdata_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_hist_q   <= bus_wr;
      rd_hist_q   <= bus_rd;
      stat_hist_q <= bus_stat_rd;
      re_q        <= ev_rd;
      rdata_q     <= rdata_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    bus_status                 = '0;
    bus_status[ST_TX_NOT_FULL] = !full;
    bus_status[ST_RX_AVAIL]    = uart_valid;
    bus_status[ST_TX_EMPTY]    = empty && (state_q == IDLE);
    bus_status[ST_OVF]         = ovf_q;
  end

  assign uart_we   = we_q;
  assign uart_di   = di_q;
  assign uart_re   = re_q;
  assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Self-checking bench for uart_tx_bridge with a queue-based reference model.
// Expectations follow UART_TX_CRLF_EN when the macro is defined.
module tb_uart_tx_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       bus_wr, bus_rd, bus_stat_rd;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata, bus_status;
  logic       uart_we, uart_wait, uart_re, uart_valid;
  logic [7:0] uart_di, uart_do;

  always #5 clk = ~clk;

  uart_tx_bridge #(.DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_wr      (bus_wr),
    .bus_rd      (bus_rd),
    .bus_stat_rd (bus_stat_rd),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_status  (bus_status),
    .uart_we     (uart_we),
    .uart_di     (uart_di),
    .uart_wait   (uart_wait),
    .uart_re     (uart_re),
    .uart_do     (uart_do),
    .uart_valid  (uart_valid)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic       ovf_m, re_m, cr_done;
  logic [7:0] rdata_m;
  logic       wr_h, rd_h, st_h;
  logic       pm;
  logic [7:0] eb;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: evaluated mid low-phase, just before each rising edge.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      mq.delete();
      ovf_m = 1'b0; re_m = 1'b0; cr_done = 1'b0;
      rdata_m = 8'h00;
      wr_h = 1'b0; rd_h = 1'b0; st_h = 1'b0;
    end else begin
      chk("status", {24'd0, bus_status},
          {24'd0, 4'b0, ovf_m, (mq.size() == 0 && !uart_we),
           uart_valid, (mq.size() != 16)});
      chk("rdata", {24'd0, bus_rdata}, {24'd0, rdata_m});
      chk("uart_re", {31'd0, uart_re}, {31'd0, re_m});
      pm = 1'b0;
      if (uart_we && !uart_wait) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL accept_empty: got %0h want none", uart_di);
        end else begin
          eb = mq[0];
          pm = 1'b1;
`ifdef UART_TX_CRLF_EN
          if (mq[0] == 8'h0A && !cr_done) begin
            eb = 8'h0D;
            pm = 1'b0;
          end
          cr_done = !pm;
`endif
          chk("uart_di", {24'd0, uart_di}, {24'd0, eb});
          sent.push_back(uart_di);
          if (pm) void'(mq.pop_front());
        end
      end
      if (bus_wr && !wr_h) begin
        if (mq.size() < 16) mq.push_back(bus_wdata);
        else ovf_m = 1'b1;
      end else if (bus_stat_rd && !st_h) begin
        ovf_m = 1'b0;
      end
      if (bus_wr && !wr_h && mq.size() == 16 && bus_stat_rd && !st_h)
        ovf_m = ovf_m;
      else if (bus_stat_rd && !st_h && !(bus_wr && !wr_h)) ovf_m = 1'b0;
      re_m = bus_rd && !rd_h;
      if (re_m) rdata_m = uart_do;
      wr_h = bus_wr; rd_h = bus_rd; st_h = bus_stat_rd;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    bus_wdata = b;
    bus_wr = 1'b1;
    tick();
    bus_wr = 1'b0;
    tick();
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 600; i++) begin
      tick();
      if (mq.size() == 0 && !uart_we) break;
    end
    if (i == 600) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got busy want idle");
    end
    tick(2);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus_wr = 0; bus_rd = 0; bus_stat_rd = 0; bus_wdata = 0;
    uart_wait = 0; uart_do = 0; uart_valid = 0;
    tick(2);
    chk("rst_status", {24'd0, bus_status}, 32'h05);
    chk("rst_we", {31'd0, uart_we}, 32'd0);
    chk("rst_rdata", {24'd0, bus_rdata}, 32'h00);
    reset = 1'b0;
    tick(2);

    sent.delete();
    bus_wdata = 8'h41;
    bus_wr = 1'b1;
    tick(6);
    bus_wr = 1'b0;
    drain();
    chk("single_cnt", sent.size(), 32'd1);
    chk("single_byte", {24'd0, sent[0]}, 32'h41);
    chk("single_status", {24'd0, bus_status}, 32'h05);

    sent.delete();
    uart_wait = 1'b1;
    for (int i = 0; i < 16; i++) wr_byte(8'h30 + 8'(i));
    chk("full_bit0", {31'd0, bus_status[0]}, 32'd0);
    wr_byte(8'h40);
    chk("ovf_status", {24'd0, bus_status}, 32'h08);
    tick(3);
    bus_stat_rd = 1'b1;
    chk("ovf_during_read", {31'd0, bus_status[3]}, 32'd1);
    tick();
    bus_stat_rd = 1'b0;
    chk("ovf_after_read", {31'd0, bus_status[3]}, 32'd0);
    tick();
    uart_wait = 1'b0;
    bus_wdata = 8'h50;
    bus_wr = 1'b1;
    tick();
    bus_wr = 1'b0;
    chk("coincide_status", {24'd0, bus_status}, 32'h00);
    drain();
    chk("order_cnt", sent.size(), 32'd17);
    for (int i = 0; i < 16; i++)
      chk("order_byte", {24'd0, sent[i]}, 32'h30 + i);
    chk("order_last", {24'd0, sent[16]}, 32'h50);

    uart_do = 8'h5A;
    uart_valid = 1'b1;
    bus_rd = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_rd = 1'b0;
      tick();
      if (uart_re) n++;
    end
    chk("re_pulses", n, 32'd1);
    chk("rx_rdata", {24'd0, bus_rdata}, 32'h5A);
    chk("rx_avail_hi", {31'd0, bus_status[1]}, 32'd1);
    uart_valid = 1'b0;
    #1;
    chk("rx_avail_lo", {31'd0, bus_status[1]}, 32'd0);
    tick();

    sent.delete();
    uart_do = 8'hC3;
    bus_wdata = 8'h61;
    bus_wr = 1'b1; bus_rd = 1'b1; bus_stat_rd = 1'b1;
    tick();
    bus_wr = 1'b0; bus_rd = 1'b0; bus_stat_rd = 1'b0;
    chk("simul_rdata", {24'd0, bus_rdata}, 32'hC3);
    chk("simul_re", {31'd0, uart_re}, 32'd1);
    drain();
    chk("simul_sent", {24'd0, sent[0]}, 32'h61);

    sent.delete();
    wr_byte(8'h0A);
    drain();
`ifdef UART_TX_CRLF_EN
    chk("lf_cnt", sent.size(), 32'd2);
    chk("lf_cr", {24'd0, sent[0]}, 32'h0D);
    chk("lf_lf", {24'd0, sent[1]}, 32'h0A);
`else
    chk("lf_cnt", sent.size(), 32'd1);
    chk("lf_lf", {24'd0, sent[0]}, 32'h0A);
`endif

    sent.delete();
    uart_wait = 1'b1;
    wr_byte(8'h77);
    tick();
    chk("send_we", {31'd0, uart_we}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async_we", {31'd0, uart_we}, 32'd0);
    chk("rst_async_status", {24'd0, bus_status}, 32'h05);
    tick(2);
    reset = 1'b0;
    uart_wait = 1'b0;
    tick(6);
    chk("rst_abort_sent", sent.size(), 32'd0);
    chk("rst_abort_we", {31'd0, uart_we}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_bridge.md
Name: uart_tx_bridge

Overview:
Memory-mapped bridge between the CPU bus decode and the simpleuart core.
- Buffers CPU byte writes (data port 0xffff) in a small TX FIFO and drains them to the UART using its busy/wait handshake, so CPU writes never stall.
- Edge-detects multi-cycle bus strobes and captures RX bytes.
- Supplies the status byte read at 0xfffd.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (16).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
bus_wr  input  1  level strobe while a CPU write to the data port is active; may stay high several cycles.
bus_rd  input  1  level strobe while a CPU read of the data port is active.
bus_stat_rd  input  1  level strobe while a CPU read of the status port is active.
bus_wdata  input  8  CPU write data.
bus_rdata  output  8  last captured RX byte.
bus_status  output  8  status byte: bit0 tx_not_full, bit1 rx_avail, bit2 tx_empty, bit3 tx_overflow (sticky), bits7:4 zero.
uart_we  output  1  write request to the UART data register.
uart_di  output  8  byte offered to the UART.
uart_wait  input  1  UART busy; a write is accepted on a cycle with uart_we=1 and uart_wait=0.
uart_re  output  1  one-cycle read pulse to the UART.
uart_do  input  8  UART receive data.
uart_valid  input  1  UART receive buffer valid.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. All registers clear on reset:
  - FIFO empty, pointers 0, count 0.
  - uart_we=0, uart_re=0, uart_di=0, bus_rdata=0, overflow=0, FSM=IDLE, strobe-history regs=0.
  - bus_status after reset is 8'h05.
- Edge detect: one registered history bit per strobe. An event fires on the cycle the strobe is 1 and its history bit is 0. Holding a strobe high produces exactly one event.
- Push: a bus_wr event writes bus_wdata into the FIFO if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Count width is DEPTH_LOG2+1. Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- Drain FSM:
  - IDLE: if the FIFO is non-empty, load uart_di from the head, assert uart_we, go to SEND.
  - SEND: hold uart_we and uart_di until the cycle uart_wait=0. On that cycle pop the FIFO, deassert uart_we next cycle, return to IDLE.
  - Minimum spacing between UART writes is 2 cycles.
  - A push into an empty FIFO reaches uart_we no earlier than the following cycle.
- RX: a bus_rd event pulses uart_re for exactly one cycle and captures uart_do into bus_rdata on that same edge. bus_rdata is stable from the next cycle until the next bus_rd event.
- Status (combinational from registers):
  - tx_not_full = count!=DEPTH.
  - rx_avail = uart_valid.
  - tx_empty = count==0 and FSM==IDLE.
- Overflow is cleared by a bus_stat_rd event. The status value presented during that read still shows overflow=1. If a set and a clear coincide, the set wins.
- Simultaneous bus_wr, bus_rd and bus_stat_rd events are all serviced in the same cycle.
- Reset asserted mid-SEND aborts the byte; uart_we drops immediately, asynchronously.

Optional Feature:
UART_TX_CRLF_EN
- With the macro defined: when the FIFO head is 8'h0A and the byte has not yet been expanded, the FSM first sends 8'h0D without popping, then sends 8'h0A and pops. This uses an extra LF_PENDING flag/state; CR costs no FIFO slot.
- Without the macro: bytes are sent verbatim, and the flag and its logic are absent.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - FSM state encoding (IDLE, SEND, CR_SEND).
  - status bit index constants (ST_TX_NOT_FULL=0, ST_RX_AVAIL=1, ST_TX_EMPTY=2, ST_OVF=3).
  - byte constants CHAR_CR=8'h0D and CHAR_LF=8'h0A.
- One sub-module: sync_fifo (parameter DEPTH_LOG2, WIDTH=8) with push, pop, head data, count.

Test Plan:
- Reset -> bus_status=8'h05, uart_we=0, bus_rdata=8'h00.
- bus_wr held high 6 cycles with data 8'h41, uart_wait=0 -> exactly one uart_we acceptance with uart_di=8'h41; FIFO empty afterwards; tx_empty=1.
- uart_wait held 1 for 100 cycles; write 17 distinct bytes 8'h30..8'h40 -> status bit0=0 after the 16th write, overflow=1 after the 17th. Release uart_wait -> 8'h30..8'h3F emerge in order and 8'h40 is never sent. One bus_stat_rd -> overflow reads 1, then 0.
- FIFO full; a write event coincides with the pop cycle -> the new byte is accepted, count stays 16, overflow stays 0.
- uart_valid=1, uart_do=8'h5A, bus_rd held 3 cycles -> uart_re high for exactly 1 cycle; bus_rdata=8'h5A the next cycle; status bit1 tracks uart_valid.
- With UART_TX_CRLF_EN, write 8'h0A -> UART accepts 8'h0D then 8'h0A. Without the macro -> only 8'h0A. Reset asserted during SEND -> uart_we=0 immediately, FIFO empty.
